// File: rtl/vga_stream_decoder.sv
// rtl/vga_stream_decoder.sv - VGA stream receiver: timing checks, lock FSM, pixel/coordinate recovery
// Optional frame CRC output enabled by defining VGA_DECODER_CRC_EN.
module vga_stream_decoder #(
    parameter int H_ACTIVE        = 640,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int H_TOTAL         = 800,
    parameter int V_ACTIVE        = 480,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int V_TOTAL         = 525,
    parameter bit SYNC_ACTIVE_LOW = 1'b0,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [1:0]  i_red,
    input  logic [1:0]  i_green,
    input  logic [1:0]  i_blue,
    output logic        o_locked,
    output logic        o_pixel_valid,
    output logic [9:0]  o_hpos,
    output logic [9:0]  o_vpos,
    output logic [5:0]  o_pixel,
    output logic        o_frame_start,
    output logic        o_line_err,
    output logic        o_frame_err,
    output logic [7:0]  o_err_count
`ifdef VGA_DECODER_CRC_EN
    ,
    output logic [15:0] o_frame_crc,
    output logic        o_crc_valid
`endif
);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_TOT     = 10'(V_TOTAL);
    localparam logic [9:0] H_START   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END     = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_START   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END     = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [3:0] LOCK_GOOD = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    // Stage 1: sampled inputs (syncs normalised to active-high) plus previous sync for edge detect
    logic       hs1_q, vs1_q, hs2_q, vs2_q;
    logic [5:0] rgb1_q;

    state_t     state_q, state_d;
    logic [3:0] good_q, good_d;
    logic       bad_q, bad_d;
    logic [9:0] hcount_q, hcount_d, vline_q, vline_d;

    logic       locked_q, valid_q, fstart_q, line_err_q, frame_err_q;
    logic [9:0] hpos_q, vpos_q;
    logic [5:0] pixel_q;
    logic [7:0] err_cnt_q;

    logic       hs_edge, vs_edge, line_err_d, frame_err_d, err_now, bad_all;
    logic       valid_d, fstart_d;
    logic [9:0] vline_seen, hpos_d, vpos_d;
    logic [5:0] pixel_d;
    logic [7:0] err_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
            rgb1_q <= '0;
        end else begin
            hs1_q  <= i_hsync ^ SYNC_ACTIVE_LOW;
            vs1_q  <= i_vsync ^ SYNC_ACTIVE_LOW;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            rgb1_q <= {i_red, i_green, i_blue};
        end
    end

    always_comb begin
        hs_edge    = hs1_q & ~hs2_q;
        vs_edge    = vs1_q & ~vs2_q;
        // Line count including the line that starts on this very hsync edge
        vline_seen = (hs_edge && vline_q != 10'h3FF) ? vline_q + 10'd1 : vline_q;
        hcount_d   = hs_edge ? 10'd0 : ((hcount_q == 10'h3FF) ? hcount_q : hcount_q + 10'd1);
        vline_d    = vs_edge ? 10'd0 : vline_seen;

        line_err_d  = hs_edge && (state_q != SEARCH) && (hcount_q != H_LAST);
        frame_err_d = vs_edge && (state_q != SEARCH) && (vline_seen != V_TOT);
        fstart_d    = vs_edge && (state_q != SEARCH);
        err_now     = line_err_d | frame_err_d;
        bad_all     = bad_q | err_now;
        bad_d       = vs_edge ? 1'b0 : bad_all;
        err_cnt_d   = (err_now && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (vs_edge) begin
                    state_d = ACQUIRE;
                    good_d  = 4'd0;
                end
            end
            ACQUIRE: begin
                if (vs_edge) begin
                    if (bad_all) begin
                        good_d = 4'd0;
                    end else begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_GOOD) state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (err_now) begin
                    state_d = ACQUIRE;
                    good_d  = 4'd0;
                end
            end
            default: state_d = SEARCH;
        endcase

        valid_d = (state_d == LOCKED) && (hcount_d >= H_START) && (hcount_d < H_END)
                  && (vline_d >= V_START) && (vline_d < V_END);
        hpos_d  = valid_d ? hcount_d - H_START : 10'd0;
        vpos_d  = valid_d ? vline_d - V_START : 10'd0;
        pixel_d = valid_d ? rgb1_q : 6'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            good_q      <= '0;
            bad_q       <= 1'b0;
            hcount_q    <= '0;
            vline_q     <= '0;
            locked_q    <= 1'b0;
            valid_q     <= 1'b0;
            hpos_q      <= '0;
            vpos_q      <= '0;
            pixel_q     <= '0;
            fstart_q    <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            hcount_q    <= hcount_d;
            vline_q     <= vline_d;
            locked_q    <= (state_d == LOCKED);
            valid_q     <= valid_d;
            hpos_q      <= hpos_d;
            vpos_q      <= vpos_d;
            pixel_q     <= pixel_d;
            fstart_q    <= fstart_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_locked      = locked_q;
    assign o_pixel_valid = valid_q;
    assign o_hpos        = hpos_q;
    assign o_vpos        = vpos_q;
    assign o_pixel       = pixel_q;
    assign o_frame_start = fstart_q;
    assign o_line_err    = line_err_q;
    assign o_frame_err   = frame_err_q;
    assign o_err_count   = err_cnt_q;

`ifdef VGA_DECODER_CRC_EN
    logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;
    logic        crc_valid_q, crc_valid_d;

    // CRC-16-CCITT, one byte MSB first
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic [7:0]  d;
        r = c;
        d = b;
        for (int i = 0; i < 8; i++) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[7]) ? 16'h1021 : 16'h0000);
            d = {d[6:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        crc_d       = crc_q;
        frame_crc_d = frame_crc_q;
        crc_valid_d = 1'b0;
        if (state_q == LOCKED && state_d != LOCKED) begin
            crc_d = 16'hFFFF;
        end else if (vs_edge && state_q == LOCKED) begin
            frame_crc_d = crc_q;
            crc_valid_d = 1'b1;
            crc_d       = 16'hFFFF;
        end else if (valid_d) begin
            crc_d = crc_byte(crc_q, {2'b00, pixel_d});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= '0;
            crc_valid_q <= 1'b0;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
            crc_valid_q <= crc_valid_d;
        end
    end

    assign o_frame_crc = frame_crc_q;
    assign o_crc_valid = crc_valid_q;
`endif

endmodule

// File: tb/tb_vga_stream_decoder.sv
// tb/tb_vga_stream_decoder.sv - self-checking bench for vga_stream_decoder (small timing, both sync polarities)
module tb_vga_stream_decoder;
    localparam int HA = 8, HS = 2, HB = 2, HT = 16;
    localparam int VA = 4, VS = 1, VB = 2, VT = 10, LF = 2;

    logic       clk = 1'b0, rst_n = 1'b0, hs = 1'b0, vs = 1'b0;
    logic [5:0] rgb = 6'd0;

    logic       a_locked, a_valid, a_fs, a_le, a_fe, b_locked, b_valid, b_fs, b_le, b_fe;
    logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos;
    logic [5:0] a_pix, b_pix;
    logic [7:0] a_ec, b_ec;
`ifdef VGA_DECODER_CRC_EN
    logic [15:0] a_crc, b_crc;
    logic        a_crcv, b_crcv;
    logic [15:0] crc_log[$];
`endif

    always #5 clk = ~clk;

    vga_stream_decoder #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT), .V_ACTIVE(VA), .V_SYNC(VS),
        .V_BP(VB), .V_TOTAL(VT), .SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(LF)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_hsync(hs), .i_vsync(vs),
        .i_red(rgb[5:4]), .i_green(rgb[3:2]), .i_blue(rgb[1:0]),
        .o_locked(a_locked), .o_pixel_valid(a_valid), .o_hpos(a_hpos), .o_vpos(a_vpos), .o_pixel(a_pix),
        .o_frame_start(a_fs), .o_line_err(a_le), .o_frame_err(a_fe), .o_err_count(a_ec)
`ifdef VGA_DECODER_CRC_EN
        , .o_frame_crc(a_crc), .o_crc_valid(a_crcv)
`endif
    );

    vga_stream_decoder #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT), .V_ACTIVE(VA), .V_SYNC(VS),
        .V_BP(VB), .V_TOTAL(VT), .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(LF)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_hsync(~hs), .i_vsync(~vs),
        .i_red(rgb[5:4]), .i_green(rgb[3:2]), .i_blue(rgb[1:0]),
        .o_locked(b_locked), .o_pixel_valid(b_valid), .o_hpos(b_hpos), .o_vpos(b_vpos), .o_pixel(b_pix),
        .o_frame_start(b_fs), .o_line_err(b_le), .o_frame_err(b_fe), .o_err_count(b_ec)
`ifdef VGA_DECODER_CRC_EN
        , .o_frame_crc(b_crc), .o_crc_valid(b_crcv)
`endif
    );

    typedef struct {
        bit         valid;
        int         hpos;
        int         vpos;
        logic [5:0] pix;
        bit         locked;
        bit         fstart;
        bit         lerr;
        bit         ferr;
        int         errs;
    } exp_t;

    typedef struct {
        int nlines;
        int sline;
        int sextra;
        int pat;
        int exp_lock;
        int exp_errs;
        int exp_valid;
    } row_t;

    exp_t q[$];
    row_t tbl[12];
    int   n_vec = 0, n_bad = 0, vcnt = 0;
    int   m_state, m_good, m_len, m_lines, m_errs;
    bit   m_bad, pm_hs, pm_vs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string t, input exp_t e, input logic v, input logic [9:0] hp, input logic [9:0] vp,
                       input logic [5:0] px, input logic lk, input logic fs, input logic le, input logic fe,
                       input logic [7:0] ec);
        check($sformatf("%s.valid@%0t", t, $time), 32'(v), 32'(e.valid));
        check($sformatf("%s.hpos@%0t", t, $time), 32'(hp), 32'(e.hpos));
        check($sformatf("%s.vpos@%0t", t, $time), 32'(vp), 32'(e.vpos));
        check($sformatf("%s.pixel@%0t", t, $time), 32'(px), 32'(e.pix));
        check($sformatf("%s.locked@%0t", t, $time), 32'(lk), 32'(e.locked));
        check($sformatf("%s.frame_start@%0t", t, $time), 32'(fs), 32'(e.fstart));
        check($sformatf("%s.line_err@%0t", t, $time), 32'(le), 32'(e.lerr));
        check($sformatf("%s.frame_err@%0t", t, $time), 32'(fe), 32'(e.ferr));
        check($sformatf("%s.err_count@%0t", t, $time), 32'(ec), 32'(e.errs));
    endtask

    task automatic chk_zero(input string t);
        exp_t z;
        z = '{default: 0};
        cmp({t, ".a"}, z, a_valid, a_hpos, a_vpos, a_pix, a_locked, a_fs, a_le, a_fe, a_ec);
        cmp({t, ".b"}, z, b_valid, b_hpos, b_vpos, b_pix, b_locked, b_fs, b_le, b_fe, b_ec);
`ifdef VGA_DECODER_CRC_EN
        check({t, ".crc"}, 32'({a_crc, a_crcv}), 32'd0);
`endif
    endtask

    task automatic model_reset();
        m_state = 0; m_good = 0; m_len = 0; m_lines = 0; m_errs = 0;
        m_bad = 1'b0; pm_hs = 1'b0; pm_vs = 1'b0;
        q.delete();
    endtask

    // Drive one pixel clock, predict the outputs it produces two clocks later.
    task automatic drive(input bit h, input bit v, input logic [5:0] p, input int col, input int line);
        exp_t e;
        bit   he, ve, le, fe;
        hs = h; vs = v; rgb = p;
        he = h & !pm_hs;
        ve = v & !pm_vs;
        pm_hs = h; pm_vs = v;
        le = he && m_state != 0 && m_len != HT;
        fe = ve && m_state != 0 && (m_lines + 1) != VT;
        e.fstart = ve && m_state != 0;
        m_len = he ? 1 : m_len + 1;
        if (ve) m_lines = 0;
        else if (he) m_lines++;
        if ((le || fe) && m_errs < 255) m_errs++;
        m_bad = m_bad | le | fe;
        case (m_state)
            0: if (ve) begin m_state = 1; m_good = 0; end
            1: if (ve) begin
                   if (m_bad) m_good = 0;
                   else m_good++;
                   if (m_good == LF) m_state = 2;
               end
            default: if (le || fe) begin m_state = 1; m_good = 0; end
        endcase
        if (ve) m_bad = 1'b0;
        e.locked = (m_state == 2);
        e.valid  = e.locked && col >= HS + HB && col < HS + HB + HA && line >= VS + VB && line < VS + VB + VA;
        e.hpos   = e.valid ? col - (HS + HB) : 0;
        e.vpos   = e.valid ? line - (VS + VB) : 0;
        e.pix    = e.valid ? p : 6'd0;
        e.lerr   = le;
        e.ferr   = fe;
        e.errs   = m_errs;
        @(posedge clk);
        q.push_back(e);
        #1;
        if (q.size() == 2) begin
            e = q.pop_front();
            cmp("a", e, a_valid, a_hpos, a_vpos, a_pix, a_locked, a_fs, a_le, a_fe, a_ec);
            cmp("b", e, b_valid, b_hpos, b_vpos, b_pix, b_locked, b_fs, b_le, b_fe, b_ec);
        end
        if (a_valid === 1'b1) vcnt++;
`ifdef VGA_DECODER_CRC_EN
        if (a_crcv === 1'b1) crc_log.push_back(a_crc);
`endif
    endtask

    // pat: 0 black, 1 gradient, 2 gradient with white first/last visible pixel, 3 black with one coloured pixel
    task automatic send_frame(input int nlines, input int sline, input int sextra, input int pat, input int maxcyc);
        int n;
        n = 0;
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < HT + ((l == sline) ? sextra : 0); c++) begin
                logic [5:0] p;
                if (n == maxcyc) return;
                case (pat)
                    0: p = 6'd0;
                    3: p = (c == 6 && l == 4) ? 6'h15 : 6'd0;
                    default: begin
                        p = 6'((c * 5 + l * 3) & 63);
                        if (pat == 2 && ((c == HS + HB && l == VS + VB) ||
                            (c == HS + HB + HA - 1 && l == VS + VB + VA - 1))) p = 6'h3F;
                    end
                endcase
                drive(c < HS, l < VS, p, c, l);
                n++;
            end
        end
    endtask

`ifdef VGA_DECODER_CRC_EN
    function automatic logic [15:0] ref_crc(input int hot_idx, input logic [7:0] hot_val);
        logic [15:0] r;
        logic [7:0]  d;
        r = 16'hFFFF;
        for (int k = 0; k < HA * VA; k++) begin
            d = (k == hot_idx) ? hot_val : 8'd0;
            for (int i = 0; i < 8; i++) begin
                r = {r[14:0], 1'b0} ^ ((r[15] ^ d[7]) ? 16'h1021 : 16'h0000);
                d = {d[6:0], 1'b0};
            end
        end
        return r;
    endfunction
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           nlines sline sextra pat lock errs valid
        tbl[0]  = '{VT, -1, 0, 1, 0, 0, 0};
        tbl[1]  = '{VT, -1, 0, 1, 0, 0, 0};
        tbl[2]  = '{VT, -1, 0, 1, 1, 0, 32};
        tbl[3]  = '{VT, -1, 0, 2, 1, 0, 32};
        tbl[4]  = '{VT,  5, 1, 1, 0, 1, 24};
        tbl[5]  = '{VT, -1, 0, 1, 0, 1, 0};
        tbl[6]  = '{VT, -1, 0, 1, 0, 1, 0};
        tbl[7]  = '{VT, -1, 0, 1, 1, 1, 32};
        tbl[8]  = '{VT - 1, -1, 0, 1, 1, 1, 32};
        tbl[9]  = '{VT, -1, 0, 1, 0, 2, 0};
        tbl[10] = '{VT, -1, 0, 1, 0, 2, 0};
        tbl[11] = '{VT, -1, 0, 1, 1, 2, 32};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 6'd0, -1, -1);

        for (int i = 0; i < 12; i++) begin
            vcnt = 0;
            send_frame(tbl[i].nlines, tbl[i].sline, tbl[i].sextra, tbl[i].pat, -1);
            check($sformatf("frame%0d.a_locked", i), 32'(a_locked), 32'(tbl[i].exp_lock));
            check($sformatf("frame%0d.b_locked", i), 32'(b_locked), 32'(tbl[i].exp_lock));
            check($sformatf("frame%0d.a_err_count", i), 32'(a_ec), 32'(tbl[i].exp_errs));
            check($sformatf("frame%0d.b_err_count", i), 32'(b_ec), 32'(tbl[i].exp_errs));
            check($sformatf("frame%0d.valid_pulses", i), 32'(vcnt), 32'(tbl[i].exp_valid));
        end

`ifdef VGA_DECODER_CRC_EN
        crc_log.delete();
        send_frame(VT, -1, 0, 0, -1);
        send_frame(VT, -1, 0, 0, -1);
        send_frame(VT, -1, 0, 3, -1);
        send_frame(VT, -1, 0, 0, -1);
        check("crc.count", 32'(crc_log.size()), 32'd4);
        if (crc_log.size() == 4) begin
            check("crc.black", 32'(crc_log[1]), 32'(ref_crc(-1, 8'd0)));
            check("crc.black_repeat", 32'(crc_log[2]), 32'(crc_log[1]));
            check("crc.one_pixel", 32'(crc_log[3]), 32'(ref_crc((4 - (VS + VB)) * HA + (6 - (HS + HB)), 8'h15)));
            check("crc.differs", 32'(crc_log[3] != crc_log[2]), 32'd1);
        end
`endif

        // Asynchronous reset in the middle of a locked frame
        send_frame(VT, -1, 0, 1, 50);
        #2 rst_n = 1'b0;
        #1 chk_zero("midreset");
        model_reset();
        hs = 1'b0; vs = 1'b0; rgb = 6'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 6'd0, -1, -1);
        for (int i = 0; i < 3; i++) begin
            vcnt = 0;
            send_frame(VT, -1, 0, 1, -1);
            check($sformatf("relock%0d.locked", i), 32'(a_locked), (i == 2) ? 32'd1 : 32'd0);
            check($sformatf("relock%0d.err_count", i), 32'(a_ec), 32'd0);
            check($sformatf("relock%0d.valid_pulses", i), 32'(vcnt), (i == 2) ? 32'd32 : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
